// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, {addr,rw}, one data byte, ACK/NACK, STOP on open-drain SCL/SDA.
// Optional clock stretching when I2C_MASTER_CLK_STRETCH_EN is defined (SCL_in ignored otherwise).
module i2c_master_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int IDLE_GAP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic       rsp_nack,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       SCL,
  output logic       SDA_out_en,
  input  logic       SDA_in,
  input  logic       SCL_in,
  output logic [3:0] dbg_state
);

  localparam int QW = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
  localparam int GW = $clog2(IDLE_GAP + 2);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR_DATA,
    S_WR_ACK, S_RD_DATA, S_M_NACK, S_STOP, S_DONE
  } state_t;

  state_t        state, state_n;
  logic [QW-1:0] qcnt;
  logic [1:0]    q;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_sh;
  logic [7:0]    rx_sh;
  logic [7:0]    wdata_q;
  logic          rw_q;
  logic [GW-1:0] gap_cnt;
  logic          accept, freeze, q_end, bit_end, sample;

  // Handshake: a command transfers on any cycle where cmd_valid and cmd_ready are both high.
  assign cmd_ready = (state == S_IDLE) && (gap_cnt == '0);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_DONE);
  assign dbg_state = state;

`ifdef I2C_MASTER_CLK_STRETCH_EN
  // SCL is released in q2 of every state except START; a slave holding it low freezes the quarter.
  assign freeze = (q == 2'd2) && (state != S_IDLE) && (state != S_START) &&
                  (state != S_DONE) && !SCL_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = SCL_in;
  assign freeze        = 1'b0;
`endif

  assign q_end   = (qcnt == QW'(CLK_DIV - 1)) && !freeze;
  assign bit_end = q_end && (q == 2'd3);
  assign sample  = q_end && (q == 2'd2);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    SCL        = 1'b1;
    SDA_out_en = 1'b1;
    case (state)
      S_IDLE: begin
        if (accept) state_n = S_START;
      end
      S_START: begin
        SCL        = ~q[1];
        SDA_out_en = 1'b0;
        if (bit_end) state_n = S_ADDR;
      end
      S_ADDR: begin
        SCL        = q[1];
        SDA_out_en = tx_sh[7];
        if (bit_end && bit_cnt == 3'd7) state_n = S_ADDR_ACK;
      end
      S_ADDR_ACK: begin
        SCL = q[1];
        if (bit_end) state_n = rsp_nack ? S_STOP : (rw_q ? S_RD_DATA : S_WR_DATA);
      end
      S_WR_DATA: begin
        SCL        = q[1];
        SDA_out_en = tx_sh[7];
        if (bit_end && bit_cnt == 3'd7) state_n = S_WR_ACK;
      end
      S_WR_ACK: begin
        SCL = q[1];
        if (bit_end) state_n = S_STOP;
      end
      S_RD_DATA: begin
        SCL = q[1];
        if (bit_end && bit_cnt == 3'd7) state_n = S_M_NACK;
      end
      S_M_NACK: begin
        SCL = q[1];
        if (bit_end) state_n = S_STOP;
      end
      S_STOP: begin
        SCL        = q[1];
        SDA_out_en = (q == 2'd3);
        if (bit_end) state_n = S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      qcnt      <= '0;
      q         <= 2'd0;
      bit_cnt   <= 3'd0;
      tx_sh     <= 8'h00;
      rx_sh     <= 8'h00;
      wdata_q   <= 8'h00;
      rw_q      <= 1'b0;
      gap_cnt   <= GW'(IDLE_GAP);
      rsp_nack  <= 1'b0;
      rsp_rdata <= 8'h00;
    end else if (state == S_IDLE) begin
      if (accept) begin
        qcnt     <= '0;
        q        <= 2'd0;
        bit_cnt  <= 3'd0;
        tx_sh    <= {cmd_addr, cmd_rw};
        wdata_q  <= cmd_wdata;
        rw_q     <= cmd_rw;
        rsp_nack <= 1'b0;
      end else if (q_end) begin
        // Idle gap is measured in whole quarter-periods of released bus.
        qcnt <= '0;
        if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
      end else begin
        qcnt <= qcnt + 1'b1;
      end
    end else if (state == S_DONE) begin
      qcnt    <= '0;
      q       <= 2'd0;
      gap_cnt <= GW'(IDLE_GAP);
    end else begin
      if (q_end) begin
        qcnt <= '0;
        q    <= q + 2'd1;
      end else if (!freeze) begin
        qcnt <= qcnt + 1'b1;
      end
      if (sample) begin
        case (state)
          S_ADDR_ACK, S_WR_ACK: if (SDA_in) rsp_nack <= 1'b1;
          S_RD_DATA:            rx_sh <= {rx_sh[6:0], SDA_in};
          default: ;
        endcase
      end
      if (bit_end) begin
        case (state)
          S_ADDR, S_WR_DATA: begin
            tx_sh   <= {tx_sh[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end
          S_RD_DATA:  bit_cnt   <= bit_cnt + 3'd1;
          S_ADDR_ACK: tx_sh     <= wdata_q;
          S_M_NACK:   rsp_rdata <= rx_sh;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed testbench for i2c_master_ctrl with a bus monitor and a simple I2C slave model.
// Stretch scenario is included when I2C_MASTER_CLK_STRETCH_EN is defined.
module tb_i2c_master_ctrl;

  localparam int CLK_DIV  = 4;
  localparam int IDLE_GAP = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_addr = 7'h00;
  logic       cmd_rw = 1'b0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid, rsp_nack, busy;
  logic [7:0] rsp_rdata;
  logic       SCL, SDA_out_en, SDA_in, SCL_in;
  logic [3:0] dbg_state;

  logic       slave_sda = 1'b1;
  logic       stretch_n = 1'b1;
  logic       slv_ack = 1'b1;
  logic [7:0] slv_rdata = 8'h00;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int fall_cnt = 0, rise_cnt = 0, start_cnt = 0, stop_cnt = 0, bad_cnt = 0;
  logic [7:0] addr_byte = 8'h00, data_byte = 8'h00;
  logic nack_rel = 1'b0;
  logic prev_scl = 1'b1, prev_line = 1'b1;

  assign SDA_in = SDA_out_en & slave_sda;
  assign SCL_in = SCL & stretch_n;

  i2c_master_ctrl #(.CLK_DIV(CLK_DIV), .IDLE_GAP(IDLE_GAP)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_rdata(rsp_rdata), .busy(busy),
    .SCL(SCL), .SDA_out_en(SDA_out_en), .SDA_in(SDA_in), .SCL_in(SCL_in),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bus monitor and slave: counts SCL edges from START, decodes bytes, drives ACK / read data.
  always @(negedge clk) begin : mon
    logic line;
    if (reset) begin
      fall_cnt  = 0;
      rise_cnt  = 0;
      slave_sda = 1'b1;
      prev_scl  = 1'b1;
      prev_line = 1'b1;
    end else begin
      if (prev_scl && !SCL) fall_cnt = fall_cnt + 1;
      slave_sda = 1'b1;
      if (slv_ack && fall_cnt == 9) slave_sda = 1'b0;
      else if (slv_ack && addr_byte[0] && fall_cnt >= 10 && fall_cnt <= 17)
        slave_sda = slv_rdata[3'(17 - fall_cnt)];
      else if (slv_ack && !addr_byte[0] && fall_cnt == 18) slave_sda = 1'b0;
      line = SDA_out_en & slave_sda;
      if (!prev_scl && SCL) begin
        rise_cnt = rise_cnt + 1;
        if (rise_cnt <= 8) addr_byte = {addr_byte[6:0], line};
        else if (rise_cnt >= 10 && rise_cnt <= 17) data_byte = {data_byte[6:0], line};
        else if (rise_cnt == 18) nack_rel = SDA_out_en;
      end
      if (SCL && (line != prev_line)) begin
        if (!prev_scl) bad_cnt = bad_cnt + 1;
        else if (!line) begin
          start_cnt = start_cnt + 1;
          fall_cnt  = 0;
          rise_cnt  = 0;
        end else stop_cnt = stop_cnt + 1;
      end
      prev_scl  = SCL;
      prev_line = line;
    end
  end

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: raise cmd_valid and return right after the accepting edge (cmd_valid left high)
  task automatic send(input string tag, input logic [6:0] a, input logic rw,
                      input logic [7:0] wd, output int t);
    logic ok;
    ok = 1'b0;
    t  = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_rw    = rw;
    cmd_wdata = wd;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        t  = cyc;
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_accepted"}, ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_start(input string tag);
    @(negedge clk);
    check({tag, "_start_scl"}, SCL, 1);
    check({tag, "_start_sda"}, SDA_out_en, 0);
    check({tag, "_start_busy"}, busy, 1);
    check({tag, "_start_ready"}, cmd_ready, 0);
    check({tag, "_start_nack_clr"}, rsp_nack, 0);
  endtask

  task automatic wait_rsp(output int rc, output logic nk, output logic [7:0] rd,
                          output logic ok, output logic leak);
    ok = 1'b0; leak = 1'b0; rc = 0; nk = 1'b0; rd = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cmd_ready) leak = 1'b1;
      if (rsp_valid) begin
        rc = cyc; nk = rsp_nack; rd = rsp_rdata; ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int t, t2, rc, k, s0, p0, b0;
    logic nk, ok, leak, seen;
    logic [7:0] rd;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_scl", SCL, 1);
    check("rst_sda", SDA_out_en, 1);
    check("rst_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_nack", rsp_nack, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_busy", busy, 0);
    k = 1;
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("rst_ready_delay", k, 9);

    // write 0x42 <- 0xA5, slave ACKs
    slv_ack = 1'b1;
    @(posedge clk); #1;
    s0 = start_cnt; p0 = stop_cnt; b0 = bad_cnt;
    send("wr", 7'h42, 1'b0, 8'hA5, t);
    cmd_valid = 1'b0;
    chk_start("wr");
    wait_rsp(rc, nk, rd, ok, leak);
    check("wr_rsp_seen", ok, 1);
    check("wr_latency", rc - t, 321);
    check("wr_nack", nk, 0);
    check("wr_ready_held", leak, 0);
    @(negedge clk);
    check("wr_rsp_pulse", rsp_valid, 0);
    check("wr_busy_end", busy, 0);
    @(posedge clk); #1;
    check("wr_addr_byte", addr_byte, 8'h84);
    check("wr_data_byte", data_byte, 8'hA5);
    check("wr_rises", rise_cnt, 19);
    check("wr_starts", start_cnt - s0, 1);
    check("wr_stops", stop_cnt - p0, 1);
    check("wr_sda_hi_change", bad_cnt - b0, 0);

    // read from 0x42, slave returns 0x3C
    slv_rdata = 8'h3C;
    s0 = start_cnt; p0 = stop_cnt; b0 = bad_cnt;
    send("rd", 7'h42, 1'b1, 8'h00, t);
    cmd_valid = 1'b0;
    chk_start("rd");
    wait_rsp(rc, nk, rd, ok, leak);
    check("rd_rsp_seen", ok, 1);
    check("rd_latency", rc - t, 321);
    check("rd_nack", nk, 0);
    check("rd_rdata", rd, 8'h3C);
    @(posedge clk); #1;
    check("rd_addr_byte", addr_byte, 8'h85);
    check("rd_line_byte", data_byte, 8'h3C);
    check("rd_master_nack", nack_rel, 1);
    check("rd_starts", start_cnt - s0, 1);
    check("rd_stops", stop_cnt - p0, 1);
    check("rd_sda_hi_change", bad_cnt - b0, 0);

    // address NACK: nobody answers 0x13
    slv_ack = 1'b0;
    s0 = start_cnt; p0 = stop_cnt;
    send("nk", 7'h13, 1'b0, 8'hFF, t);
    cmd_valid = 1'b0;
    chk_start("nk");
    wait_rsp(rc, nk, rd, ok, leak);
    check("nk_rsp_seen", ok, 1);
    check("nk_latency", rc - t, 177);
    check("nk_nack", nk, 1);
    check("nk_rdata_hold", rd, 8'h3C);
    @(posedge clk); #1;
    check("nk_addr_byte", addr_byte, 8'h26);
    check("nk_rises", rise_cnt, 10);
    check("nk_starts", start_cnt - s0, 1);
    check("nk_stops", stop_cnt - p0, 1);

    // back-to-back: second command (read) held valid through the first (write)
    slv_ack   = 1'b1;
    slv_rdata = 8'hC3;
    send("b2b1", 7'h42, 1'b0, 8'h5A, t);
    cmd_addr  = 7'h42;
    cmd_rw    = 1'b1;
    cmd_wdata = 8'h00;
    chk_start("b2b1");
    wait_rsp(rc, nk, rd, ok, leak);
    check("b2b1_rsp_seen", ok, 1);
    check("b2b1_latency", rc - t, 321);
    check("b2b1_ready_held", leak, 0);
    k  = 0;
    t2 = 0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      k++;
      if (cmd_ready) begin
        t2   = cyc;
        seen = 1'b1;
        break;
      end
    end
    check("b2b_ready_seen", seen, 1);
    check("b2b_ready_gap", k, 9);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk_start("b2b2");
    check("b2b_start_ge8", (t2 + 1 - rc) >= 8, 1);
    wait_rsp(rc, nk, rd, ok, leak);
    check("b2b2_rsp_seen", ok, 1);
    check("b2b2_latency", rc - t2, 321);
    check("b2b2_rdata", rd, 8'hC3);
    check("b2b2_nack", nk, 0);

    // reset during the address byte
    send("rst", 7'h42, 1'b0, 8'h11, t);
    cmd_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      if (rise_cnt == 5) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_mid_reached", seen, 1);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mid_scl", SCL, 1);
    check("rst_mid_sda", SDA_out_en, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_rsp", rsp_valid, 0);
    check("rst_mid_rdata", rsp_rdata, 0);
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("rst_mid_no_rsp", seen, 0);
    send("post", 7'h42, 1'b0, 8'h77, t);
    cmd_valid = 1'b0;
    chk_start("post");
    wait_rsp(rc, nk, rd, ok, leak);
    check("post_rsp_seen", ok, 1);
    check("post_latency", rc - t, 321);
    check("post_nack", nk, 0);
    check("post_rdata_hold", rd, 8'h00);
    @(posedge clk); #1;
    check("post_data_byte", data_byte, 8'h77);

`ifdef I2C_MASTER_CLK_STRETCH_EN
    // slave stretches SCL for 20 clocks in data bit 5
    send("st", 7'h42, 1'b0, 8'hA5, t);
    cmd_valid = 1'b0;
    chk_start("st");
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      if (rise_cnt == 11) begin
        seen = 1'b1;
        break;
      end
    end
    check("st_reached", seen, 1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!SCL) break;
    end
    stretch_n = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (SCL) break;
    end
    repeat (19) @(negedge clk);
    @(posedge clk); #1 stretch_n = 1'b1;
    wait_rsp(rc, nk, rd, ok, leak);
    check("st_rsp_seen", ok, 1);
    check("st_latency", rc - t, 341);
    check("st_nack", nk, 0);
    @(posedge clk); #1;
    check("st_data_byte", data_byte, 8'hA5);
`endif

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
